// File: rtl/led_fader_pkg.sv
// led_fader shared definitions: default brightness width,
// full-scale derivation and the brightness type.
package led_fader_pkg;

   localparam int PWM_W_DEF = 6;

   function automatic int bmax_f(input int w);
      return (1 << w) - 1;
   endfunction

   typedef logic [PWM_W_DEF-1:0] bright_t;

endpackage

// File: rtl/led_fader_ch.sv
// One fader channel: brightness register with load/decay,
// PWM compare and the registered pad drive.
module led_fader_ch
   import led_fader_pkg::*;
#(
   parameter int PWM_W      = PWM_W_DEF,
   parameter int DECAY_STEP = 1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             en,
   input  logic             decay_tick,
   input  logic             led_in,
   input  logic [PWM_W-1:0] pwm_cnt,
   output logic             led_out
);

   localparam logic [PWM_W-1:0] BMAX = PWM_W'(bmax_f(PWM_W));
   localparam logic [PWM_W-1:0] STEP = PWM_W'(DECAY_STEP);

   logic [PWM_W-1:0] b_q, b_d;
   logic             out_q, out_d;

   // load wins over decay; decay saturates at zero
   always_comb begin
      b_d   = b_q;
      out_d = 1'b0;
      if (en) begin
         if (led_in) begin
            b_d = BMAX;
         end else if (decay_tick) begin
            b_d = (b_q > STEP) ? (b_q - STEP) : '0;
         end
         out_d = (b_q == BMAX) | (b_q > pwm_cnt);
      end
   end

   // brightness and output flops
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         b_q   <= '0;
         out_q <= 1'b0;
      end else begin
         b_q   <= b_d;
         out_q <= out_d;
      end
   end

   assign led_out = out_q;

endmodule

// File: rtl/led_fader.sv
// Per-channel PWM fade stage: shared PWM counter and decay
// prescaler driving one fader channel per LED.
module led_fader
   import led_fader_pkg::*;
#(
   parameter int N_CH       = 8,
   parameter int PWM_W      = PWM_W_DEF,
   parameter int DECAY_DIV  = 65536,
   parameter int DECAY_STEP = 1
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic            en,
   input  logic [N_CH-1:0] led_in,
   output logic [N_CH-1:0] led_out
);

   localparam int DIV_W = $clog2(DECAY_DIV);
   localparam logic [DIV_W-1:0] LAST = DIV_W'(DECAY_DIV - 1);

   logic [PWM_W-1:0] pwm_q, pwm_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             decay_tick;

   // counters advance only while enabled; prescaler wraps at LAST
   always_comb begin
      pwm_d = pwm_q;
      div_d = div_q;
      if (en) begin
         pwm_d = pwm_q + 1'b1;
         div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
      end
   end

   assign decay_tick = en & (div_q == LAST);

   // PWM counter and decay prescaler flops
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         pwm_q <= '0;
         div_q <= '0;
      end else begin
         pwm_q <= pwm_d;
         div_q <= div_d;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      led_fader_ch #(
         .PWM_W      (PWM_W),
         .DECAY_STEP (DECAY_STEP)
      ) u_ch (
         .clk        (clk),
         .rst_l      (rst_l),
         .en         (en),
         .decay_tick (decay_tick),
         .led_in     (led_in[i]),
         .pwm_cnt    (pwm_q),
         .led_out    (led_out[i])
      );
   end

endmodule

// File: doc/led_fader.md
# led_fader

Per-channel PWM fade stage driven by the one-hot LED walker pattern. Each channel lights at full brightness while its input bit is high. After the input drops, brightness decays linearly to zero, which leaves a fading trail behind the running light. The block sits between the walker's registered `led[7:0]` and the output pad buffers, in the same clock domain, so no synchronisers are needed.

## Interface
- `N_CH`, default 8: number of channels.
- `PWM_W`, default 6: brightness and PWM counter width. Full-scale brightness `BMAX = 2**PWM_W - 1`.
- `DECAY_DIV`, default 65536: clocks per decay tick. Legal range is 2 or more.
- `DECAY_STEP`, default 1: brightness decrement per tick. Legal range is 1 to `BMAX`.
- `clk` (in, 1): single clock. All state changes on its rising edge.
- `rst_l` (in, 1): reset, asynchronous and active-low.
- `en` (in, 1): run enable. Low freezes all state.
- `led_in` (in, `N_CH`): pattern from the walker, registered upstream on `clk`.
- `led_out` (out, `N_CH`): registered PWM drive to the pads.

## Operation
- PWM counter `pwm_cnt` (`PWM_W` bits):
  - Free-running while `en` is high; +1 per clock.
  - Wraps from `BMAX` to 0.
- Decay prescaler `div_cnt` (0 to `DECAY_DIV-1`):
  - +1 per clock while `en` is high; wraps to 0.
  - `decay_tick` is a combinational pulse, high when `div_cnt == DECAY_DIV-1` and `en` is high.
- Per-channel brightness `b[i]` (`PWM_W` bits), evaluated in priority order while `en` is high:
  1. `led_in[i]` high: `b[i] <= BMAX`. Load beats decay when both occur in the same cycle.
  2. Else if `decay_tick`: `b[i] <= (b[i] > DECAY_STEP) ? b[i] - DECAY_STEP : 0`. Subtraction saturates at 0 and never wraps.
  3. Else: hold.
- Output compare, registered: `led_out[i] <= en & ((b[i] == BMAX) | (b[i] > pwm_cnt))`.
  - `BMAX` gives 100 % duty.
  - 0 gives 0 % duty.
  - Intermediate value `k` gives a duty of `k / 2**PWM_W`.
- `en` low:
  - `pwm_cnt`, `div_cnt` and all `b[i]` hold.
  - `led_in` is ignored.
  - `led_out` goes to 0 on the next edge.
  - When `en` returns high, operation resumes from the frozen values.
- Full fade time after the input drops: `ceil(BMAX / DECAY_STEP)` ticks, i.e. up to that many × `DECAY_DIV` clocks.

## Timing
- Reset, asynchronous on `rst_l` low. All of the following hold until the first rising edge after `rst_l` deasserts:
  - `pwm_cnt` = 0
  - `div_cnt` = 0
  - every `b[i]` = 0
  - `led_out` = 0
- Reset mid-fade discards all brightness state; there is no partial restore.
- Latency from `led_in[i]` rising at edge n:
  - `b[i] = BMAX` after edge n+1.
  - `led_out[i] = 1` after edge n+2.
- Channel turn-off is governed only by decay; there is no immediate clear.
- A one-cycle `led_in` pulse loads full brightness exactly as a long pulse does.
- Wrap-around:
  - `div_cnt` and `pwm_cnt` wrap in the same cycle without interaction.
  - Ticks are exactly `DECAY_DIV` clocks apart while `en` is held high.
- Multiple `led_in` bits high at once are legal; channels are fully independent.

## Structure
- Package `led_fader_pkg` holds:
  - the default `PWM_W` value
  - the `BMAX` derivation function
  - the brightness typedef `bright_t`
- Sub-module `led_fader_ch`, one instance per channel through a generate loop. It contains:
  - the brightness register
  - the load/decay mux
  - the comparator
  - the `led_out` flop
- Top level holds only `pwm_cnt`, `div_cnt`, `decay_tick` and the instances.

## Test plan
All scenarios use `PWM_W=3` (so `BMAX=7`), `DECAY_DIV=4` and `DECAY_STEP=1` unless stated otherwise.
- Reset mid-fade:
  - Stimulus: pulse `led_in[2]`; wait 10 clocks; drive `rst_l` low asynchronously between edges.
  - Response: `led_out` = 0x00 immediately; `b[2]` = 0.
  - After `rst_l` release: `led_out` stays 0x00 until new input.
- Single pulse:
  - Stimulus: `led_in` = 0x08 for 1 cycle at edge 0.
  - Response: `b[3]` = 7 after edge 1; `led_out[3]` high from edge 2.
  - `b[3]` then steps 6, 5, …, 0, one step every 4 clocks.
  - After 7 ticks `led_out[3]` stays 0.
- Held input:
  - Stimulus: `led_in` = 0x01 held for 40 clocks.
  - Response: `led_out[0]` constantly 1 from edge 2; `b[0]` stays 7 across every tick (load priority).
- Walker trail:
  - Stimulus: one-hot rotating left every 8 clocks.
  - Response: the channel one position behind holds `b` = 5 and the channel two behind holds `b` = 3 at the moment of each shift.
  - Duty measured over 8 clocks equals `b`/8.
- Enable freeze:
  - Stimulus: `en` low for 20 clocks with `b[1]` = 4, then `en` high.
  - Response: `led_out` = 0 during the freeze; `b[1]` = 4 on resume; `div_cnt` continues from its frozen value.
- Saturation:
  - Stimulus: `DECAY_STEP=3`; pulse `led_in[5]`.
  - Response: `b[5]` sequence is 7 → 4 → 1 → 0 → 0, with no wrap to 6.
